// File: rtl/fxn_pkg.sv
`default_nettype none
//============================================================================
// Module : fxn_pkg
// Brief  : Shared function codes, default widths and queue entry type for
//          the mini-ALU result path.
// Rev    : 1.0  initial release
//============================================================================
package fxn_pkg;

    localparam int DEF_DATA_W = 6;
    localparam int DEF_FXN_W  = 3;

    localparam logic [2:0] FXN_ADD  = 3'd0;
    localparam logic [2:0] FXN_SUB  = 3'd1;
    localparam logic [2:0] FXN_AND  = 3'd2;
    localparam logic [2:0] FXN_OR   = 3'd3;
    localparam logic [2:0] FXN_XOR  = 3'd4;
    localparam logic [2:0] FXN_NAND = 3'd5;
    localparam logic [2:0] FXN_NOR  = 3'd6;
    localparam logic [2:0] FXN_XNOR = 3'd7;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_FXN_W-1:0]  fxn;
        logic                  zero;
    } fxnEntry_t;

    function automatic int fxnChW(input int nCh);
        return (nCh > 1) ? $clog2(nCh) : 1;
    endfunction

    // Default map image: entry 4 -> channel 1, entry 5 -> channel 2, rest 0.
    function automatic logic [63:0] defResetMap(input int chW);
        logic [63:0] mask;
        mask = (64'd1 << chW) - 64'd1;
        return ((64'd1 & mask) << (4 * chW)) | ((64'd2 & mask) << (5 * chW));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fxn_result_sel_if.sv
`default_nettype none
//============================================================================
// Module : fxn_result_sel_if
// Brief  : Input, map-programming and output handshake bundle of the
//          result selector.
// Rev    : 1.0  initial release
//============================================================================
interface fxn_result_sel_if
    import fxn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FXN_W  = DEF_FXN_W,
    parameter int N_CH   = 3
);
    localparam int CH_W = fxnChW(N_CH);

    logic                   in_valid;
    logic                   in_ready;
    logic [FXN_W-1:0]       in_fxn;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic                   map_we;
    logic [FXN_W-1:0]       map_addr;
    logic [CH_W-1:0]        map_ch;
    logic                   map_err;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic [FXN_W-1:0]       out_fxn;
    logic                   out_zero;

    modport master (
        output in_valid, in_fxn, ch_data, map_we, map_addr, map_ch, out_ready,
        input  in_ready, map_err, out_valid, out_data, out_fxn, out_zero
    );

    modport slave (
        input  in_valid, in_fxn, ch_data, map_we, map_addr, map_ch, out_ready,
        output in_ready, map_err, out_valid, out_data, out_fxn, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/fxn_result_fifo2.sv
`default_nettype none
//============================================================================
// Module : fxn_result_fifo2
// Brief  : Two-entry valid/ready queue; ready depends only on the stored count.
// Rev    : 1.0  initial release
//============================================================================
module fxn_result_fifo2 #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         i_pushValid,
    output logic              o_pushReady,
    input  wire logic [W-1:0] i_pushData,
    output logic              o_popValid,
    input  wire logic         i_popReady,
    output logic [W-1:0]      o_popData
);
    localparam logic [1:0] c_FULL = 2'd2;

    logic [1:0]   r_count;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         w_push;
    logic         w_pop;

    assign w_push = i_pushValid && (r_count != c_FULL);
    assign w_pop  = (r_count != 2'd0) && i_popReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_push, w_pop})
                // Simultaneous push/pop only happens at count 1: replace head.
                2'b11: r_head <= i_pushData;
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_pushData;
                    end else begin
                        r_tail <= i_pushData;
                    end
                    r_count <= r_count + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_pushReady = (r_count != c_FULL);
    assign o_popValid  = (r_count != 2'd0);
    assign o_popData   = o_popValid ? r_head : '0;
endmodule
`default_nettype wire

// File: rtl/fxn_result_sel.sv
`default_nettype none
//============================================================================
// Module : fxn_result_sel
// Brief  : Function-code steered result selector with programmable code map
//          and a two-entry output queue tagging fxn code and zero flag.
// Rev    : 1.0  initial release
//============================================================================
module fxn_result_sel
    import fxn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FXN_W  = DEF_FXN_W,
    parameter int N_CH   = 3,
    parameter logic [(2**FXN_W)*fxnChW(N_CH)-1:0] RESET_MAP =
        ((2**FXN_W)*fxnChW(N_CH))'(defResetMap(fxnChW(N_CH)))
) (
    input  wire logic clk,
    input  wire logic rst_n,
    fxn_result_sel_if.slave bus
);
    localparam int CH_W  = fxnChW(N_CH);
    localparam int N_ENT = 2**FXN_W;
    localparam int ENT_W = DATA_W + FXN_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [FXN_W-1:0]  fxn;
        logic              zero;
    } entry_t;

    // Out-of-range reset entries fall back to channel 0 so the mux never overruns.
    function automatic logic [N_ENT*CH_W-1:0] clampMap(input logic [N_ENT*CH_W-1:0] raw);
        logic [N_ENT*CH_W-1:0] res;
        res = '0;
        for (int i = 0; i < N_ENT; i++) begin
            if ({1'b0, raw[i*CH_W +: CH_W]} < (CH_W+1)'(N_CH)) begin
                res[i*CH_W +: CH_W] = raw[i*CH_W +: CH_W];
            end
        end
        return res;
    endfunction

    localparam logic [N_ENT*CH_W-1:0] c_rstMap = clampMap(RESET_MAP);

    logic [CH_W-1:0]   r_mapTbl [N_ENT];
    logic              r_mapErr;
    logic              w_chOk;
    logic [DATA_W-1:0] w_chArr  [N_CH];
    logic [CH_W-1:0]   w_selCh;
    logic [DATA_W-1:0] w_selData;
    entry_t            w_pushEnt;
    entry_t            w_headEnt;
    logic              w_inReady;
    logic              w_outValid;

    assign w_chOk = ({1'b0, bus.map_ch} < (CH_W+1)'(N_CH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENT; i++) begin
                r_mapTbl[i] <= c_rstMap[i*CH_W +: CH_W];
            end
            r_mapErr <= 1'b0;
        end else begin
            if (bus.map_we && w_chOk) begin
                r_mapTbl[bus.map_addr] <= bus.map_ch;
            end
            r_mapErr <= bus.map_we && !w_chOk;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_chSplit
        assign w_chArr[k] = bus.ch_data[k*DATA_W +: DATA_W];
    end

    // Map read and channel data are both taken pre-edge, so a same-cycle map
    // write only affects the following accept.
    assign w_selCh        = r_mapTbl[bus.in_fxn];
    assign w_selData      = w_chArr[w_selCh];
    assign w_pushEnt.data = w_selData;
    assign w_pushEnt.fxn  = bus.in_fxn;
    assign w_pushEnt.zero = (w_selData == '0);

    fxn_result_fifo2 #(
        .W (ENT_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_pushValid (bus.in_valid),
        .o_pushReady (w_inReady),
        .i_pushData  (w_pushEnt),
        .o_popValid  (w_outValid),
        .i_popReady  (bus.out_ready),
        .o_popData   (w_headEnt)
    );

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.out_data  = w_headEnt.data;
    assign bus.out_fxn   = w_headEnt.fxn;
    assign bus.out_zero  = w_headEnt.zero;
    assign bus.map_err   = r_mapErr;
endmodule
`default_nettype wire

// File: tb/tb_fxn_result_sel.sv
`default_nettype none
//============================================================================
// Module : tb_fxn_result_sel
// Brief  : Self-checking bench: directed scenarios plus random traffic
//          against a queue-based reference model.
// Rev    : 1.0  initial release
//============================================================================
module tb_fxn_result_sel;
    import fxn_pkg::*;

    localparam int DW = 6;
    localparam int FW = 3;
    localparam int NC = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fxn_result_sel_if #(.DATA_W(DW), .FXN_W(FW), .N_CH(NC)) bus ();

    fxn_result_sel #(.DATA_W(DW), .FXN_W(FW), .N_CH(NC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int        nTests = 0;
    int        nFail  = 0;
    fxnEntry_t refQ[$];
    int        refMap[8];
    bit        errPend;
    bit        lastAcc;

    task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void refReset();
        refQ.delete();
        errPend = 1'b0;
        foreach (refMap[i]) refMap[i] = 0;
        refMap[4] = 1;
        refMap[5] = 2;
    endfunction

    task automatic checkOutputs();
        chkVal("in_ready",  32'(bus.in_ready),  32'(refQ.size() < 2));
        chkVal("out_valid", 32'(bus.out_valid), 32'(refQ.size() > 0));
        chkVal("map_err",   32'(bus.map_err),   32'(errPend));
        if (refQ.size() > 0) begin
            chkVal("out_data", 32'(bus.out_data), 32'(refQ[0].data));
            chkVal("out_fxn",  32'(bus.out_fxn),  32'(refQ[0].fxn));
            chkVal("out_zero", 32'(bus.out_zero), 32'(refQ[0].zero));
        end else begin
            chkVal("idle_data", 32'(bus.out_data), 32'd0);
            chkVal("idle_fxn",  32'(bus.out_fxn),  32'd0);
            chkVal("idle_zero", 32'(bus.out_zero), 32'd0);
        end
    endtask

    // One clock edge of the reference: pop head, push selected channel, then map update.
    task automatic modelEdge();
        fxnEntry_t e;
        int        ch;
        bit        acc;
        bit        pop;
        acc    = bus.in_valid && (refQ.size() < 2);
        pop    = (refQ.size() > 0) && bus.out_ready;
        ch     = refMap[bus.in_fxn];
        e.data = DW'(bus.ch_data >> (DW * ch));
        e.fxn  = bus.in_fxn;
        e.zero = (e.data == 0);
        if (pop) refQ.delete(0);
        if (acc) refQ.push_back(e);
        errPend = bus.map_we && (int'(bus.map_ch) >= NC);
        if (bus.map_we && int'(bus.map_ch) < NC) refMap[bus.map_addr] = int'(bus.map_ch);
        lastAcc = acc;
    endtask

    task automatic step();
        @(negedge clk);
        checkOutputs();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int fxn, input logic [NC*DW-1:0] data);
        bus.in_valid = v;
        bus.in_fxn   = FW'(fxn);
        bus.ch_data  = data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got3;
        bus.in_valid  = 1'b0;
        bus.in_fxn    = '0;
        bus.ch_data   = '0;
        bus.map_we    = 1'b0;
        bus.map_addr  = '0;
        bus.map_ch    = '0;
        bus.out_ready = 1'b1;
        refReset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        step();

        // Map entry 4 selects channel 1 out of reset
        drive(1'b1, 4, {6'h00, 6'h15, 6'h00});
        step();
        bus.in_valid = 1'b0;
        chkVal("t1_valid", 32'(bus.out_valid), 32'd1);
        chkVal("t1_data",  32'(bus.out_data),  32'h15);
        chkVal("t1_fxn",   32'(bus.out_fxn),   32'd4);
        chkVal("t1_zero",  32'(bus.out_zero),  32'd0);
        step();

        // Full-rate streaming
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i, 18'($urandom));
            step();
            chkVal("t2_fxn_order", 32'(bus.out_fxn),  32'(i));
            chkVal("t2_ready",     32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        step();

        // Backpressure: two accepts fill the queue, third is held
        bus.out_ready = 1'b0;
        drive(1'b1, 1, 18'($urandom)); step();
        drive(1'b1, 2, 18'($urandom)); step();
        drive(1'b1, 3, 18'($urandom)); step();
        step();
        chkVal("t3_full", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        got3 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (lastAcc) begin
                got3 = 1'b1;
                bus.in_valid = 1'b0;
            end
        end
        chkVal("t3_third_taken", 32'(got3), 32'd1);

        // Map write with same-cycle accept uses the old entry
        bus.map_we = 1'b1; bus.map_addr = 3'd0; bus.map_ch = 2'd2;
        drive(1'b1, 0, {6'h2A, 6'h0B, 6'h11});
        step();
        bus.map_we = 1'b0;
        chkVal("t4_old_map", 32'(bus.out_data), 32'h11);
        step();
        chkVal("t4_new_map", 32'(bus.out_data), 32'h2A);
        bus.in_valid = 1'b0;
        step();

        // Rejected map write
        bus.map_we = 1'b1; bus.map_addr = 3'd1; bus.map_ch = 2'd3;
        step();
        bus.map_we = 1'b0;
        chkVal("t5_err_pulse", 32'(bus.map_err), 32'd1);
        step();
        chkVal("t5_err_clear", 32'(bus.map_err), 32'd0);
        drive(1'b1, 1, {6'h03, 6'h05, 6'h00});
        step();
        bus.in_valid = 1'b0;
        chkVal("t5_zero", 32'(bus.out_zero), 32'd1);
        chkVal("t5_data", 32'(bus.out_data), 32'd0);
        step();

        // Reset with two entries queued
        bus.out_ready = 1'b0;
        drive(1'b1, 2, 18'($urandom)); step();
        drive(1'b1, 3, 18'($urandom)); step();
        bus.in_valid = 1'b0;
        chkVal("t6_pre_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chkVal("t6_async_valid", 32'(bus.out_valid), 32'd0);
        refReset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        drive(1'b1, 0, {6'h09, 6'h00, 6'h07});
        step();
        bus.in_valid = 1'b0;
        chkVal("t6_map_revert", 32'(bus.out_data), 32'h07);
        step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_fxn    = FW'($urandom);
            bus.ch_data   = ($urandom_range(0, 3) == 0) ? '0 : 18'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.map_we    = ($urandom_range(0, 7) == 0);
            bus.map_addr  = FW'($urandom);
            bus.map_ch    = 2'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
`default_nettype wire
